// File: rtl/ra_return_checker_pkg.sv
// Shared return-address encoding constants, FSM state codes and the decode helper.
// The branch-unit encoder and the return checker must agree on RA_KEY.
package ra_return_checker_pkg;

    localparam int unsigned RA_VLEN     = 32;
    localparam int unsigned LOST_W      = 8;
    localparam logic [RA_VLEN-2:0] RA_KEY      = 31'h73fa06c2;
    localparam logic               RA_CODE_MSB = 1'b1;

    localparam logic [1:0] ST_NORMAL     = 2'd0;
    localparam logic [1:0] ST_OVERFLOWED = 2'd1;
    localparam logic [1:0] ST_FAULT      = 2'd2;

    typedef logic [1:0] ra_chk_state_e;

    typedef struct packed {
        logic [RA_VLEN-1:0] addr;
        logic               plain;
    } ra_dec_t;

    // An encoded link has bit VLEN-1 set; anything else is a plain (suspicious) target.
    function automatic ra_dec_t ra_decode(input logic [RA_VLEN-1:0] enc,
                                          input logic [RA_VLEN-2:0] key,
                                          input logic               code_msb);
        ra_dec_t d;
        d.plain = ~enc[RA_VLEN-1];
        d.addr  = d.plain ? enc : {code_msb, enc[RA_VLEN-2:0] ^ key};
        return d;
    endfunction

endpackage

// File: rtl/ra_shadow_lifo.sv
// Circular shadow stack of plain link addresses; a push into a full stack
// overwrites the oldest entry. Simultaneous push+pop replaces the top.
module ra_shadow_lifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               data_i,
    output logic [W-1:0]               top_c,
    output logic                       full_c,
    output logic                       empty_c,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PTR_W-1:0] top_idx;

    assign top_idx = wr_q - 1'b1;
    assign top_c   = mem_q[top_idx];
    assign full_c  = (cnt_q == CNT_W'(DEPTH));
    assign empty_c = (cnt_q == '0);
    assign count_o = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            unique case ({push_i, pop_i})
                2'b10: begin
                    mem_q[wr_q] <= data_i;
                    wr_q        <= wr_q + 1'b1;
                    if (!full_c) cnt_q <= cnt_q + 1'b1;
                end
                2'b01: begin
                    if (!empty_c) begin
                        wr_q  <= wr_q - 1'b1;
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                2'b11: begin
                    // Pop-then-push: on an empty stack this degenerates to a plain push.
                    if (empty_c) begin
                        mem_q[wr_q] <= data_i;
                        wr_q        <= wr_q + 1'b1;
                        cnt_q       <= cnt_q + 1'b1;
                    end else begin
                        mem_q[top_idx] <= data_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ra_return_checker.sv
// Return-side decode and shadow-stack validation of encoded return addresses.
// Optional event counters (calls_o/rets_o/faults_o) are built when RA_CHECK_STATS_EN is defined.
module ra_return_checker #(
    parameter int unsigned      DEPTH    = 8,
    parameter int unsigned      VLEN     = 32,
    parameter logic [VLEN-2:0]  RA_KEY   = ra_return_checker_pkg::RA_KEY,
    parameter logic             CODE_MSB = ra_return_checker_pkg::RA_CODE_MSB
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    valid_i,
    input  logic                    is_call_i,
    input  logic                    is_ret_i,
    input  logic [VLEN-1:0]         link_addr_i,
    input  logic [VLEN-1:0]         enc_target_i,
    input  logic                    clear_i,
    output logic                    ready_o,
    output logic                    dec_valid_o,
    output logic [VLEN-1:0]         dec_target_o,
    output logic                    crash_o,
    output logic [$clog2(DEPTH):0]  depth_o
`ifdef RA_CHECK_STATS_EN
    ,
    output logic [31:0]             calls_o,
    output logic [31:0]             rets_o,
    output logic [31:0]             faults_o
`endif
);

    import ra_return_checker_pkg::RA_VLEN;
    import ra_return_checker_pkg::LOST_W;
    import ra_return_checker_pkg::ST_NORMAL;
    import ra_return_checker_pkg::ST_OVERFLOWED;
    import ra_return_checker_pkg::ST_FAULT;
    import ra_return_checker_pkg::ra_chk_state_e;
    import ra_return_checker_pkg::ra_dec_t;
    import ra_return_checker_pkg::ra_decode;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    ra_chk_state_e     state_q, state_d;
    logic [LOST_W-1:0] lost_q, lost_d;
    logic              ready_q, crash_q, dec_valid_q;
    logic [VLEN-1:0]   dec_target_q;

    logic              accept_c, ret_c, call_c;
    logic              unchecked_c, mismatch_c;
    logic              push_c, pop_c, lifo_clr_c;
    ra_dec_t           dec_c;
    logic [VLEN-1:0]   dec_addr_c;
    logic [VLEN-1:0]   lifo_top;
    logic              lifo_full, lifo_empty;
    logic [CNT_W-1:0]  lifo_count;

    assign dec_c      = ra_decode(RA_VLEN'(enc_target_i), (RA_VLEN-1)'(RA_KEY), CODE_MSB);
    assign dec_addr_c = VLEN'(dec_c.addr);

    assign accept_c = valid_i && ready_q;
    assign ret_c    = accept_c && is_ret_i;
    assign call_c   = accept_c && is_call_i;

    ra_shadow_lifo #(
        .DEPTH (DEPTH),
        .W     (VLEN)
    ) u_lifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (lifo_clr_c),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .data_i  (link_addr_i),
        .top_c   (lifo_top),
        .full_c  (lifo_full),
        .empty_c (lifo_empty),
        .count_o (lifo_count)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_NORMAL;
            lost_q  <= '0;
        end else begin
            state_q <= state_d;
            lost_q  <= lost_d;
        end
    end

    // Next-state and stack control; a faulting event leaves the stack untouched
    always_comb begin
        state_d     = state_q;
        lost_d      = lost_q;
        push_c      = 1'b0;
        pop_c       = 1'b0;
        lifo_clr_c  = 1'b0;
        unchecked_c = 1'b0;
        mismatch_c  = 1'b0;
        unique case (state_q)
            ST_NORMAL, ST_OVERFLOWED: begin
                unchecked_c = ret_c && lifo_empty && (state_q == ST_OVERFLOWED) &&
                              (lost_q != '0);
                mismatch_c  = ret_c && !unchecked_c &&
                              (lifo_empty || dec_c.plain || (dec_addr_c != lifo_top));
                if (mismatch_c) begin
                    state_d = ST_FAULT;
                end else begin
                    pop_c  = ret_c && !lifo_empty;
                    push_c = call_c;
                    if (unchecked_c) begin
                        lost_d = lost_q - 1'b1;
                        if (lost_q == LOST_W'(1)) state_d = ST_NORMAL;
                    end
                    if (call_c && lifo_full && !pop_c) begin
                        if (lost_q != '1) lost_d = lost_q + 1'b1;
                        state_d = ST_OVERFLOWED;
                    end
                end
            end
            ST_FAULT: begin
                if (clear_i) begin
                    state_d    = ST_NORMAL;
                    lost_d     = '0;
                    lifo_clr_c = 1'b1;
                end
            end
            default: state_d = ST_NORMAL;
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_q      <= 1'b0;
            crash_q      <= 1'b0;
            dec_valid_q  <= 1'b0;
            dec_target_q <= '0;
        end else begin
            ready_q     <= (state_d != ST_FAULT);
            crash_q     <= (state_d == ST_FAULT);
            dec_valid_q <= ret_c;
            if (ret_c) dec_target_q <= dec_addr_c;
        end
    end

    assign ready_o      = ready_q;
    assign crash_o      = crash_q;
    assign dec_valid_o  = dec_valid_q;
    assign dec_target_o = dec_target_q;
    assign depth_o      = lifo_count;

`ifdef RA_CHECK_STATS_EN
    logic [31:0] calls_q, rets_q, faults_q;

    // Wrapping event counters, cleared only by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            calls_q  <= '0;
            rets_q   <= '0;
            faults_q <= '0;
        end else begin
            if (call_c) calls_q <= calls_q + 1'b1;
            if (ret_c)  rets_q  <= rets_q + 1'b1;
            if ((state_d == ST_FAULT) && (state_q != ST_FAULT)) faults_q <= faults_q + 1'b1;
        end
    end

    assign calls_o  = calls_q;
    assign rets_o   = rets_q;
    assign faults_o = faults_q;
`endif

endmodule

// File: tb/tb_ra_return_checker.sv
// Scoreboard bench for ra_return_checker: directed scenarios plus randomized
// call/return traffic checked against a queue-based shadow-stack model.
module tb_ra_return_checker;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned VLEN  = 32;
    localparam logic [30:0] KEY   = 31'h73fa06c2;

    logic            clk;
    logic            rst_n;
    logic            valid, is_call, is_ret, clear;
    logic [VLEN-1:0] link_addr, enc_target;
    logic            ready, dec_valid, crash;
    logic [VLEN-1:0] dec_target;
    logic [3:0]      depth;
`ifdef RA_CHECK_STATS_EN
    logic [31:0]     calls, rets, faults;
`endif

    ra_return_checker #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .valid_i      (valid),
        .is_call_i    (is_call),
        .is_ret_i     (is_ret),
        .link_addr_i  (link_addr),
        .enc_target_i (enc_target),
        .clear_i      (clear),
        .ready_o      (ready),
        .dec_valid_o  (dec_valid),
        .dec_target_o (dec_target),
        .crash_o      (crash),
        .depth_o      (depth)
`ifdef RA_CHECK_STATS_EN
        ,
        .calls_o      (calls),
        .rets_o       (rets),
        .faults_o     (faults)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] tgt;
        logic        crash;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] stk[$];
    int          lost;
    bit          crashed;
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, req);
    endfunction

    function automatic logic [31:0] encode(input logic [31:0] a);
        return {1'b1, a[30:0] ^ KEY};
    endfunction

    // Reference: a bounded list of live links plus a count of links lost to overflow
    function automatic void model_step(input bit v, input bit c, input bit r,
                                       input logic [31:0] link, input logic [31:0] enc,
                                       input bit clr);
        logic [31:0] dec;
        bit          plain;
        exp_t        e;
        if (crashed) begin
            if (clr) begin
                crashed = 1'b0;
                stk.delete();
                lost = 0;
            end
            return;
        end
        if (!v) return;
        if (r) begin
            plain = !enc[31];
            dec   = plain ? enc : {1'b1, enc[30:0] ^ KEY};
            e.tgt = dec;
            if (stk.size() == 0 && lost > 0) begin
                lost--;
            end else if (stk.size() == 0 || plain || dec != stk[$]) begin
                crashed = 1'b1;
                e.crash = 1'b1;
                exp_q.push_back(e);
                return;
            end else begin
                void'(stk.pop_back());
            end
            e.crash = 1'b0;
            exp_q.push_back(e);
        end
        if (c) begin
            if (stk.size() == DEPTH) begin
                void'(stk.pop_front());
                if (lost < 255) lost++;
            end
            stk.push_back(link);
        end
    endfunction

    task automatic issue(input bit c, input bit r, input logic [31:0] link,
                         input logic [31:0] enc, input bit clr);
        @(negedge clk);
        valid      = c | r;
        is_call    = c;
        is_ret     = r;
        link_addr  = link;
        enc_target = enc;
        clear      = clr;
        model_step(c | r, c, r, link, enc, clr);
        @(posedge clk);
        #1;
        valid   = 1'b0;
        is_call = 1'b0;
        is_ret  = 1'b0;
        clear   = 1'b0;
    endtask

    task automatic status(input string tag);
        @(negedge clk);
        chk({tag, "_crash"}, 32'(crash), 32'(crashed));
        chk({tag, "_ready"}, 32'(ready), 32'(!crashed));
        if (!crashed) chk({tag, "_depth"}, 32'(depth), 32'(stk.size()));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_crash"},      32'(crash),     32'd0);
        chk({tag, "_ready"},      32'(ready),     32'd0);
        chk({tag, "_dec_valid"},  32'(dec_valid), 32'd0);
        chk({tag, "_dec_target"}, dec_target,     32'd0);
        chk({tag, "_depth"},      32'(depth),     32'd0);
    endtask

    // Monitor: every decoded-target pulse must match the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && dec_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL dec_valid_unexpected: actual=1 required=0 target=%h", dec_target);
                end else begin
                    e = exp_q.pop_front();
                    chk("dec_target", dec_target, e.tgt);
                    chk("dec_crash", 32'(crash), 32'(e.crash));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] links[9];
        logic [31:0] link, enc;
        int          sel, p;
        bit          c, r;

        rst_n = 1'b0; valid = 1'b0; is_call = 1'b0; is_ret = 1'b0; clear = 1'b0;
        link_addr = '0; enc_target = '0;
        lost = 0; crashed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        status("post_reset");

        // Matching call/return pair
        issue(1, 0, 32'h80000104, 32'h0, 0);
        issue(0, 1, 32'h0, 32'hF3FA07C6, 0);
        status("match");

        // Wrong target, then clear with a simultaneous return that must be ignored
        issue(1, 0, 32'h80000104, 32'h0, 0);
        issue(0, 1, 32'h0, 32'hF3FA07C2, 0);
        status("mismatch");
        issue(0, 1, 32'h0, 32'hF3FA07C6, 1);
        status("clear");

        // Plain (unencoded) return target
        issue(1, 0, 32'h80000104, 32'h0, 0);
        issue(0, 1, 32'h0, 32'h80000104, 0);
        status("plain");
        issue(0, 0, 32'h0, 32'h0, 1);
        status("clear2");

        // Overflow by one, then unwind all nine calls
        for (int i = 0; i < 9; i++) begin
            links[i] = 32'h80001000 + 32'(4 * i);
            issue(1, 0, links[i], 32'h0, 0);
        end
        status("overflow");
        for (int i = 8; i >= 0; i--) issue(0, 1, 32'h0, encode(links[i]), 0);
        status("unwind");

        // Empty return back in NORMAL must fault
        issue(0, 1, 32'h0, encode(32'h80000200), 0);
        status("empty_ret");

        // Asynchronous reset while faulted
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("fault_reset");
        stk.delete(); lost = 0; crashed = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        status("post_reset2");

        // Simultaneous return+call replaces the top
        issue(1, 0, 32'h80000300, 32'h0, 0);
        issue(1, 1, 32'h80000400, encode(32'h80000300), 0);
        status("ret_call");
        issue(0, 1, 32'h0, encode(32'h80000400), 0);
        status("ret_call_pop");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (crashed) begin
                issue(0, 0, 32'h0, 32'h0, 1);
                status("rnd_clear");
                continue;
            end
            sel  = int'($urandom_range(99));
            c    = (sel < 50) || (sel >= 80 && sel < 92);
            r    = (sel >= 50 && sel < 92);
            link = {1'b1, 31'($urandom)};
            p    = int'($urandom_range(99));
            if (stk.size() > 0 && p < 88) enc = encode(stk[$]);
            else if (p < 94)              enc = {1'b0, 31'($urandom)};
            else                          enc = {1'b1, 31'($urandom)};
            issue(c, r, link, enc, 0);
            status("rnd");
        end

        repeat (2) @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
